// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and the double-dabble adjust helper
// for the multiplexed 7-segment scan controller.
package seg_pkg;

   localparam int          NDIG        = 6;
   localparam logic [23:0] DEC_MAX     = 24'd999999;
   localparam logic [23:0] OVF_PATTERN = 24'hFFFFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
   function automatic logic [27:0] dd_adjust(input logic [27:0] bcd);
      logic [27:0] r;
      r = bcd;
      for (int k = 0; k < 7; k++) begin
         if (r[4*k +: 4] >= 4'd5) begin
            r[4*k +: 4] = r[4*k +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: 24-bit binary to BCD, one bit per cycle.
// The first iteration happens on the start edge itself, so done_o pulses
// 24 cycles after start and the result is then held until the next start.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [23:0] bin_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [23:0] bcd_o
);

   logic [27:0] bcd_q, bcd_d;
   logic [23:0] sh_q,  sh_d;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;

   // One double-dabble iteration on the current accumulator / shift register.
   always_comb begin
      logic [27:0] adj;
      adj   = dd_adjust(bcd_q);
      bcd_d = {adj[26:0], sh_q[23]};
      sh_d  = {sh_q[22:0], 1'b0};
   end

   // Iteration sequencing; reset aborts any conversion in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bcd_q  <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i && !busy_q) begin
            bcd_q  <= {27'd0, bin_i[23]};
            sh_q   <= {bin_i[22:0], 1'b0};
            cnt_q  <= 5'd1;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            bcd_q <= bcd_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q[23:0];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 6-digit multiplexed 7-segment sequencer: load handshake, decimal/hex
// display register, digit scan, brightness PWM and leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter logic [15:0] DWELL = 16'd20000,
   parameter int          PWM_W = 4
) (
   input  logic             iCLK,
   input  logic             iRST_n,
   input  logic [23:0]      iNum,
   input  logic             iIsHex,
   input  logic             iLoad,
   input  logic             iLZB,
   input  logic [PWM_W-1:0] iBright,
   output logic             oBusy,
   output logic             oOvf,
   output logic [3:0]       oDigit,
   output logic [5:0]       oSel
);

   state_e           state_q;
   logic [23:0]      num_q;
   logic [23:0]      disp_q;
   logic             hex_q;
   logic             busy_q;
   logic             ovf_q;

   logic [15:0]      dwell_q, dwell_d;
   logic [2:0]       idx_q,   idx_d;
   logic [PWM_W-1:0] pwm_q,   pwm_d;
   logic [3:0]       digit_q, digit_d;
   logic [5:0]       sel_q,   sel_d;

   logic             accept;
   logic             cvt_start;
   logic             cvt_busy;
   logic             cvt_done;
   logic [23:0]      cvt_bcd;

   assign accept    = iLoad && !busy_q;
   assign cvt_start = (state_q == IDLE) && accept && !iIsHex;

   bin2bcd_seq u_bin2bcd (
      .clk_i   (iCLK),
      .rst_ni  (iRST_n),
      .start_i (cvt_start),
      .bin_i   (iNum),
      .busy_o  (cvt_busy),
      .done_o  (cvt_done),
      .bcd_o   (cvt_bcd)
   );

   // Load FSM: hex loads land immediately, decimal loads go through the
   // converter and the display register is only written whole in COMMIT.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= IDLE;
         num_q   <= '0;
         disp_q  <= '0;
         hex_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  num_q <= iNum;
                  hex_q <= iIsHex;
                  if (iIsHex) begin
                     disp_q <= iNum;
                     ovf_q  <= 1'b0;
                  end else begin
                     state_q <= CONV;
                     busy_q  <= 1'b1;
                  end
               end
            end
            CONV: begin
               if (cvt_done) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               if (num_q > DEC_MAX) begin
                  disp_q <= OVF_PATTERN;
                  ovf_q  <= 1'b1;
               end else begin
                  disp_q <= cvt_bcd;
                  ovf_q  <= 1'b0;
               end
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Free-running dwell / digit index / PWM counters, independent of the FSM.
   always_comb begin
      pwm_d   = pwm_q + 1'b1;
      dwell_d = dwell_q + 16'd1;
      idx_d   = idx_q;
      if (dwell_q == DWELL - 16'd1) begin
         dwell_d = '0;
         idx_d   = (idx_q == 3'(NDIG - 1)) ? 3'd0 : idx_q + 3'd1;
      end
   end

   // Output selection: nibble for the current index plus all blank sources.
   always_comb begin
      logic pwm_blank;
      logic lzb_blank;
      logic edge_blank;
      digit_d    = disp_q[{idx_q, 2'b00} +: 4];
      pwm_blank  = (pwm_q >= iBright) && (iBright != '1);
      lzb_blank  = !hex_q && iLZB && !ovf_q && (idx_q != 3'd0) &&
                   ((disp_q >> {idx_q, 2'b00}) == 24'd0);
      edge_blank = (dwell_q == DWELL - 16'd1);
      sel_d      = ~(6'b100000 >> idx_q);
      if (pwm_blank || lzb_blank || edge_blank) begin
         sel_d = 6'b111111;
      end
   end

   // Scan counters and registered digit/select outputs.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         dwell_q <= '0;
         idx_q   <= '0;
         pwm_q   <= '0;
         digit_q <= '0;
         sel_q   <= 6'b111111;
      end else begin
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         pwm_q   <= pwm_d;
         digit_q <= digit_d;
         sel_q   <= sel_d;
      end
   end

   assign oBusy  = busy_q;
   assign oOvf   = ovf_q;
   assign oDigit = digit_q;
   assign oSel   = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle model built from time arithmetic and a
// busy countdown, compared every cycle, plus literal display expectations.
module tb_seg_scan_ctrl;

   localparam int DWI = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [23:0] num;
   logic        ishex, load, lzb;
   logic [3:0]  bright;
   logic        busy, ovf;
   logic [3:0]  dig;
   logic [5:0]  sel;

   int checks   = 0;
   int failures = 0;

   // model state
   int          m_t;
   int          m_bcnt;
   logic [23:0] m_disp, m_pend;
   logic        m_ovf, m_hex;
   logic        g_lzb;
   logic [3:0]  g_br;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DWELL(16'(DWI)), .PWM_W(4)) dut (
      .iCLK    (clk),
      .iRST_n  (rst_n),
      .iNum    (num),
      .iIsHex  (ishex),
      .iLoad   (load),
      .iLZB    (lzb),
      .iBright (bright),
      .oBusy   (busy),
      .oOvf    (ovf),
      .oDigit  (dig),
      .oSel    (sel)
   );

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      r = '0;
      for (int k = 0; k < 6; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = 0; m_bcnt = 0; m_disp = '0; m_pend = '0; m_ovf = 1'b0; m_hex = 1'b0;
   endtask

   // Drive one cycle, predict the outputs after the edge, compare them.
   task automatic step(input logic ld, input logic [23:0] n, input logic hx);
      int dwell, idx, pwm;
      logic blank;
      logic [3:0] e_dig;
      logic [5:0] e_sel;
      load = ld; num = n; ishex = hx; lzb = g_lzb; bright = g_br;
      dwell = m_t % DWI;
      idx   = (m_t / DWI) % 6;
      pwm   = m_t % 16;
      e_dig = m_disp[4*idx +: 4];
      blank = ((pwm >= int'(g_br)) && (g_br != 4'hF)) ||
              (!m_hex && g_lzb && !m_ovf && idx > 0 && ((m_disp >> (4*idx)) == 24'd0)) ||
              (dwell == DWI - 1);
      e_sel = blank ? 6'h3F : ~(6'b100000 >> idx);
      if (m_bcnt > 0) begin
         m_bcnt--;
         if (m_bcnt == 0) begin
            if (m_pend > 24'd999999) begin
               m_disp = 24'hFFFFFF; m_ovf = 1'b1;
            end else begin
               m_disp = to_bcd(int'(m_pend)); m_ovf = 1'b0;
            end
         end
      end else if (ld) begin
         m_hex = hx;
         if (hx) begin
            m_disp = n; m_ovf = 1'b0;
         end else begin
            m_pend = n; m_bcnt = 25;
         end
      end
      m_t++;
      @(posedge clk); #1;
      chk("busy", 32'(busy), 32'(m_bcnt > 0));
      chk("ovf",  32'(ovf),  32'(m_ovf));
      chk("digit", 32'(dig), 32'(e_dig));
      chk("sel",  32'(sel),  32'(e_sel));
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 60) begin
         n++;
         step(1'b0, 24'd0, 1'b0);
      end
      chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic scan_collect(output logic [23:0] seen, output logic [5:0] shown);
      seen = '0; shown = '0;
      for (int c = 0; c < 24; c++) begin
         step(1'b0, 24'd0, 1'b0);
         for (int k = 0; k < 6; k++) begin
            if (sel == ~(6'b100000 >> k)) begin
               seen[4*k +: 4] = dig;
               shown[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic count_active(input int cycles, output int act);
      act = 0;
      for (int c = 0; c < cycles; c++) begin
         step(1'b0, 24'd0, 1'b0);
         if (sel != 6'h3F) act++;
      end
   endtask

   initial begin
      logic [23:0] seen;
      logic [5:0]  shown;
      int n;
      rst_n = 1'b0; num = '0; ishex = 1'b0; load = 1'b0; lzb = 1'b0; bright = 4'hF;
      g_lzb = 1'b0; g_br = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel",   32'(sel),  32'h3F);
      chk("rst_digit", 32'(dig),  32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_ovf",   32'(ovf),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // hex load
      step(1'b1, 24'h12AB3F, 1'b1);
      chk("hex_busy", 32'(busy), 32'h0);
      count_active(24, n);
      chk("hex_active_cycles", 32'(n), 32'd18);
      scan_collect(seen, shown);
      chk("hex_digits", 32'(seen), 32'h12AB3F);
      chk("hex_shown", 32'(shown), 32'h3F);

      // decimal load
      step(1'b1, 24'd987654, 1'b0);
      chk("dec_no_early_update", 32'(dig == 4'hF || dig == 4'h3 || dig == 4'hB ||
                                      dig == 4'hA || dig == 4'h2 || dig == 4'h1), 32'd1);
      n = 0;
      while (busy && n < 60) begin
         n++;
         step(1'b0, 24'd0, 1'b0);
      end
      chk("dec_busy_len", 32'(n), 32'd25);
      scan_collect(seen, shown);
      chk("dec_digits", 32'(seen), 32'h987654);
      chk("dec_ovf", 32'(ovf), 32'h0);

      // overflow, then hex clears it
      step(1'b1, 24'd1000000, 1'b0);
      wait_idle(n);
      scan_collect(seen, shown);
      chk("ovf_digits", 32'(seen), 32'hFFFFFF);
      chk("ovf_flag", 32'(ovf), 32'h1);
      step(1'b1, 24'h000123, 1'b1);
      step(1'b0, 24'd0, 1'b0);
      chk("ovf_cleared", 32'(ovf), 32'h0);

      // leading-zero blanking
      g_lzb = 1'b1;
      step(1'b1, 24'd42, 1'b0);
      wait_idle(n);
      scan_collect(seen, shown);
      chk("lzb42_shown", 32'(shown), 32'h03);
      chk("lzb42_digits", 32'(seen), 32'h000042);
      step(1'b1, 24'd0, 1'b0);
      wait_idle(n);
      scan_collect(seen, shown);
      chk("lzb0_shown", 32'(shown), 32'h01);
      chk("lzb0_digits", 32'(seen), 32'h0);
      g_lzb = 1'b0;

      // brightness
      step(1'b1, 24'h111111, 1'b1);
      g_br = 4'd4;
      count_active(48, n);
      chk("bright4_active", 32'(n), 32'd9);
      g_br = 4'd0;
      count_active(32, n);
      chk("bright0_active", 32'(n), 32'd0);
      g_br = 4'hF;

      // load during conversion is dropped
      step(1'b1, 24'd123456, 1'b0);
      repeat (5) step(1'b0, 24'd0, 1'b0);
      step(1'b1, 24'd999, 1'b0);
      wait_idle(n);
      scan_collect(seen, shown);
      chk("midload_digits", 32'(seen), 32'h123456);

      // reset during conversion
      step(1'b1, 24'd500000, 1'b0);
      repeat (10) step(1'b0, 24'd0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mrst_sel",  32'(sel),  32'h3F);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_digit", 32'(dig), 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) step(1'b0, 24'd0, 1'b0);
      scan_collect(seen, shown);
      chk("mrst_digits", 32'(seen), 32'h0);
      chk("mrst_shown", 32'(shown), 32'h3F);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         logic        l;
         logic [23:0] v;
         case ($urandom_range(0, 3))
            0:       v = 24'($urandom_range(0, 99));
            1:       v = 24'($urandom_range(0, 999999));
            2:       v = 24'($urandom_range(1000000, 16777215));
            default: v = 24'($urandom);
         endcase
         l = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) g_lzb = 1'($urandom);
         if ($urandom_range(0, 31) == 0) g_br = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         step(l, v, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequencing controller for the 6-digit multiplexed 7-segment display.
- Accepts a 24-bit value via a valid/busy handshake and converts it to BCD serially (double-dabble), or passes it raw in hex mode.
- Owns digit scan timing, brightness PWM and leading-zero blanking.
- Outputs a 4-bit digit code plus active-low digit selects; the existing hex-to-segment decoder sits downstream.

Parameters:
- DWELL, 16'd20000, iCLK cycles each digit stays selected (must be ≥ 2).
- PWM_W, 4, brightness resolution in bits.

Ports:
- iCLK  in  1  system clock
- iRST_n  in  1  asynchronous active-low reset
- iNum  in  24  value to display
- iIsHex  in  1  1 = show iNum as 6 hex nibbles; 0 = decimal
- iLoad  in  1  load request; accepted when iLoad && !oBusy
- iLZB  in  1  leading-zero blanking enable (decimal mode only)
- iBright  in  PWM_W  duty: 0 = dark, all-ones = always on, else iBright/2^PWM_W
- oBusy  out  1  conversion in progress; loads ignored while high
- oOvf  out  1  last decimal load exceeded 999999
- oDigit  out  4  nibble for the currently selected digit
- oSel  out  6  active-low digit select; digit k (nibble k) drives oSel[5-k]

Behaviour:
- Reset (async, iRST_n=0):
  - Display register = 0, digit index = 0, dwell and PWM counters = 0, FSM = IDLE.
  - Outputs: oSel=6'b111111, oDigit=0, oBusy=0, oOvf=0.
  - Reset mid-conversion aborts it; the partial result is discarded.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE, accept, hex mode: display register <= iNum and oOvf <= 0 on the next edge. oBusy stays 0. Stay in IDLE.
  - IDLE, accept, decimal mode: latch iNum into the shift register; go to CONV. oBusy=1 from the next cycle.
  - CONV: 24 iterations, one per cycle. Add 3 to each BCD nibble ≥ 5, then shift left 1. The BCD accumulator is 28 bits; only the low 24 are used. Go to COMMIT after iteration 24.
  - COMMIT, 1 cycle:
    - Latched value ≤ 999999: display <= BCD, oOvf <= 0.
    - Latched value > 999999: display <= 24'hFFFFFF, oOvf <= 1.
    - Go to IDLE; oBusy falls next cycle.
  - Decimal busy duration: exactly 25 cycles (24 CONV + 1 COMMIT). The display register changes only on a COMMIT or hex-accept edge, never partially.
  - iLoad while oBusy=1 is dropped; no queueing.
- Scan:
  - Dwell counter runs 0..DWELL-1 continuously, independent of the FSM.
  - On wrap, digit index advances 0→1→…→5→0.
  - oDigit = display nibble [index]; registered, so 1 cycle of latency from index/display change.
- Blank conditions (oSel=6'b111111; oDigit still driven):
  - PWM: a free-running PWM_W-bit counter ≥ iBright, unless iBright is all-ones.
  - Leading-zero blanking: decimal mode, iLZB=1, oOvf=0, index > 0, and all nibbles from index..5 are zero. Digit 0 is never blanked.
  - Dwell boundary: dwell counter == DWELL-1, to prevent ghosting on digit switch.
- Otherwise oSel = ~(6'b100000 >> index). Registered, aligned with oDigit.
- The mode used for blanking (iIsHex) is latched at accept, not sampled live.

Decomposition:
- Package seg_pkg holds:
  - NDIG=6
  - DEC_MAX=24'd999999
  - FSM state enum {IDLE, CONV, COMMIT}
  - OVF_PATTERN=24'hFFFFFF
- Sub-module bin2bcd_seq: serial double-dabble with handshake ports start, busy, done (1-cycle pulse) and a 24-bit result. seg_scan_ctrl instantiates it and implements the COMMIT/overflow logic around it.

Test Plan:
- Reset, then hex load of 24'h12AB3F with iBright=4'hF, DWELL=4 → oBusy stays 0. Over 24 cycles oDigit cycles F,3,B,A,2,1 with oSel=011111,101111,…,111110. oSel=111111 on each boundary cycle.
- Decimal load of 24'd987654 → oBusy high exactly 25 cycles. Display becomes 24'h987654 only after COMMIT; oOvf=0.
- Decimal load of 24'd1000000 → after 25 cycles all digits 4'hF, oOvf=1. A following hex load clears oOvf.
- Decimal load of 24'd42 with iLZB=1 → digits 2..5 blanked (oSel=111111), digits 0,1 show 2,4. A load of 24'd0 shows only digit 0 = 0.
- iBright=4'd4, PWM_W=4 → on a selected digit, oSel is active 4 of every 16 cycles. iBright=0 → oSel never leaves 111111.
- Second iLoad pulsed mid-conversion → ignored, first result committed. iRST_n pulsed low at CONV iteration 10 → immediate oSel=111111, oBusy=0, display 0, no COMMIT afterward.
